matriz_varredura_param: RTL and testbench



---
 rtl/matriz_pkg.sv | 67 ++++++
 rtl/glifo_rom.sv | 33 +++
 rtl/matriz_varredura_param.sv | 123 ++++++++++++
 tb/tb_matriz_varredura_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared types, glyph bitmaps and glyph selection for the LED matrix scanner.
package matriz_pkg;

   localparam int GLY_ROWS = 7;
   localparam int GLY_COLS = 5;

   typedef enum logic [2:0] {
      GLY_BLANK,
      GLY_CRITICO,
      GLY_BAIXO,
      GLY_MEDIO,
      GLY_ALTO,
      GLY_ASPERSAO,
      GLY_GOTEJAMENTO
   } glifo_e;

   // Frame snapshot of the controller status lines.
   typedef struct packed {
      logic critico;
      logic baixo;
      logic medio;
      logic alto;
      logic aspersao;
      logic gotejamento;
   } snap_t;

   // Index 0 is the top row; within a row the MSB is the leftmost column,
   // so each literal reads like the picture it draws.
   typedef logic [0:GLY_ROWS-1][GLY_COLS-1:0] bitmap_t;

   localparam bitmap_t BMP_CRITICO     = {5'b01110, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b01110};
   localparam bitmap_t BMP_BAIXO       = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b11110};
   localparam bitmap_t BMP_MEDIO       = {5'b10001, 5'b11011, 5'b10101, 5'b10001, 5'b10001, 5'b10001, 5'b10001};
   localparam bitmap_t BMP_ALTO        = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
   localparam bitmap_t BMP_ASPERSAO    = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
   localparam bitmap_t BMP_GOTEJAMENTO = {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01110};

   // Picture-order row of a glyph (MSB = leftmost column).
   function automatic logic [GLY_COLS-1:0] linha_glifo(glifo_e g, logic [2:0] r);
      bitmap_t b;
      case (g)
         GLY_CRITICO:     b = BMP_CRITICO;
         GLY_BAIXO:       b = BMP_BAIXO;
         GLY_MEDIO:       b = BMP_MEDIO;
         GLY_ALTO:        b = BMP_ALTO;
         GLY_ASPERSAO:    b = BMP_ASPERSAO;
         GLY_GOTEJAMENTO: b = BMP_GOTEJAMENTO;
         default:         b = '0;
      endcase
      return b[r];
   endfunction

   // Critical level overrides both phases; otherwise phase picks level or mode.
   function automatic glifo_e sel_glifo(snap_t s, logic fase);
      if (s.critico)          return GLY_CRITICO;
      if (!fase) begin
         if (s.baixo)         return GLY_BAIXO;
         if (s.medio)         return GLY_MEDIO;
         if (s.alto)          return GLY_ALTO;
         return GLY_BLANK;
      end
      if (s.aspersao)         return GLY_ASPERSAO;
      if (s.gotejamento)      return GLY_GOTEJAMENTO;
      return GLY_BLANK;
   endfunction

endpackage

// File: rtl/glifo_rom.sv
// Combinational glyph lookup: (glyph, row) -> column pattern, col[0] = leftmost.
// Glyphs are anchored top-left; rows/cols beyond the 7x5 art read as 0.
module glifo_rom
   import matriz_pkg::*;
#(
   parameter int COLS = 5,
   parameter int RW   = 3
) (
   input  glifo_e            glifo,
   input  logic [RW-1:0]     linha,
   output logic [COLS-1:0]   padrao
);

   logic [GLY_COLS-1:0] pic;

   // Fetch the picture row, blank below the authored glyph height.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pic = '0;
      if (int'(linha) < GLY_ROWS)
         pic = linha_glifo(glifo, 3'(linha));
   end

   // Mirror picture order into col[0] = leftmost; pad or crop to COLS.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c < GLY_COLS) begin : g_art
         assign padrao[c] = pic[GLY_COLS-1-c];
      end else begin : g_pad
         assign padrao[c] = 1'b0;
      end
   end

endmodule

// File: rtl/matriz_varredura_param.sv
// Self-clocked row scanner for the irrigation-status LED matrix.
// Prescaler -> row -> frame counters, per-frame input snapshot, registered outputs.
module matriz_varredura_param
   import matriz_pkg::*;
#(
   parameter int ROWS         = 7,
   parameter int COLS         = 5,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 2,
   parameter int ALT_FRAMES   = 50
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Enable,
   input  logic              Critico,
   input  logic              Baixo,
   input  logic              Medio,
   input  logic              Alto,
   input  logic              Aspersao,
   input  logic              Gotejamento,
   output logic [ROWS-1:0]   lin,
   output logic [COLS-1:0]   col,
   output logic              frame_start,
   output logic              phase
);

   localparam int PW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int RW = (ROWS       > 1) ? $clog2(ROWS)       : 1;
   localparam int FW = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;

   logic [PW-1:0]   presc;
   logic [RW-1:0]   row;
   logic [FW-1:0]   frame;
   logic            phase_q;
   snap_t           snap;
   snap_t           live;
   snap_t           snap_sel;
   glifo_e          glifo;
   logic [COLS-1:0] padrao;
   logic            first;
   logic            last_presc;
   logic            last_row;
   logic            last_frame;
   logic            blank;

   assign live       = '{critico: Critico, baixo: Baixo, medio: Medio, alto: Alto,
                         aspersao: Aspersao, gotejamento: Gotejamento};
   assign first      = Enable && (presc == '0) && (row == '0);
   assign last_presc = (presc == PW'(SCAN_DIV - 1));
   assign last_row   = (row   == RW'(ROWS - 1));
   assign last_frame = (frame == FW'(ALT_FRAMES - 1));
   assign blank      = (int'(presc) < BLANK_CYCLES);

   // The first slot of a frame already uses the values being captured.
   assign snap_sel   = first ? live : snap;
   assign glifo      = sel_glifo(snap_sel, phase_q);

   glifo_rom #(
      .COLS (COLS),
      .RW   (RW)
   ) u_rom (
      .glifo  (glifo),
      .linha  (row),
      .padrao (padrao)
   );

   // Cascaded scan counters; all hold while Enable is low.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         presc   <= '0;
         row     <= '0;
         frame   <= '0;
         phase_q <= 1'b0;
      end else if (Enable) begin
         if (last_presc) begin
            presc <= '0;
            if (last_row) begin
               row <= '0;
               if (last_frame) begin
                  frame   <= '0;
                  phase_q <= ~phase_q;
               end else begin
                  frame <= frame + 1'b1;
               end
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Capture the status lines once per frame so a frame never tears.
   always_ff @(posedge Clock) begin
      if (!Reset)
         snap <= '0;
      else if (first)
         snap <= live;
   end

   // Registered pin drivers, one cycle behind the counters.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         lin         <= '1;
         col         <= '0;
         frame_start <= 1'b0;
         phase       <= 1'b0;
      end else begin
         phase       <= phase_q;
         frame_start <= first;
         if (Enable && !blank) begin
            lin <= ~(ROWS'(1) << row);
            col <= padrao;
         end else begin
            lin <= '1;
            col <= '0;
         end
      end
   end

endmodule

// File: tb/tb_matriz_varredura_param.sv
// Randomised and directed bench for matriz_varredura_param with a timeline
// reference model (position = enabled cycles since reset).
module tb_matriz_varredura_param;

   localparam int ROWS  = 7;
   localparam int COLS  = 5;
   localparam int DIV   = 4;
   localparam int BLANK = 1;
   localparam int ALT   = 2;
   localparam int FRAME = ROWS * DIV;

   logic            Clock = 1'b0;
   logic            Reset = 1'b0;
   logic            Enable = 1'b1;
   logic            Critico = 1'b1, Baixo = 1'b1, Medio = 1'b1, Alto = 1'b1;
   logic            Aspersao = 1'b1, Gotejamento = 1'b1;
   logic [ROWS-1:0] lin;
   logic [COLS-1:0] col;
   logic            frame_start;
   logic            phase;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   int         t = 0;
   logic [5:0] snap_m = '0;

   matriz_varredura_param #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK), .ALT_FRAMES(ALT)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable),
      .Critico(Critico), .Baixo(Baixo), .Medio(Medio), .Alto(Alto),
      .Aspersao(Aspersao), .Gotejamento(Gotejamento),
      .lin(lin), .col(col), .frame_start(frame_start), .phase(phase)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // Glyph art, top row first, leftmost column first.
   function automatic string art(input string name);
      case (name)
         "C": return {".XXX.", "X...X", "X....", "X....", "X....", "X...X", ".XXX."};
         "B": return {"XXXX.", "X...X", "X...X", "XXXX.", "X...X", "X...X", "XXXX."};
         "M": return {"X...X", "XX.XX", "X.X.X", "X...X", "X...X", "X...X", "X...X"};
         "A": return {".XXX.", "X...X", "X...X", "XXXXX", "X...X", "X...X", "X...X"};
         "S": return {".XXXX", "X....", "X....", ".XXX.", "....X", "....X", "XXXX."};
         "G": return {".XXX.", "X...X", "X....", "X.XXX", "X...X", "X...X", ".XXX."};
         default: return {".....", ".....", ".....", ".....", ".....", ".....", "....."};
      endcase
   endfunction

   // s = {critico, baixo, medio, alto, aspersao, gotejamento}
   function automatic string pick(input logic [5:0] s, input int ph);
      if (s[5]) return "C";
      if (ph == 0) return s[4] ? "B" : s[3] ? "M" : s[2] ? "A" : "-";
      return s[1] ? "S" : s[0] ? "G" : "-";
   endfunction

   function automatic logic [COLS-1:0] row_bits(input string name, input int r);
      string a;
      logic [COLS-1:0] v;
      a = art(name);
      v = '0;
      for (int c = 0; c < COLS; c++)
         v[c] = (a[r*COLS + c] == "X");
      return v;
   endfunction

   // One clock: predict from pre-edge state, clock, then compare.
   task automatic step();
      logic [ROWS-1:0] e_lin;
      logic [COLS-1:0] e_col;
      logic            e_fs;
      int              e_ph;
      logic [5:0]      cur, s;
      int              presc, row;
      cur   = {Critico, Baixo, Medio, Alto, Aspersao, Gotejamento};
      e_lin = '1;
      e_col = '0;
      e_fs  = 1'b0;
      if (!Reset) begin
         t = 0;
         snap_m = '0;
         e_ph = 0;
      end else begin
         e_ph = (t / FRAME / ALT) % 2;
         if (Enable) begin
            presc = t % DIV;
            row   = (t / DIV) % ROWS;
            s     = snap_m;
            if (t % FRAME == 0) begin
               snap_m = cur;
               s      = cur;
               e_fs   = 1'b1;
            end
            if (presc >= BLANK) begin
               e_lin = ~(ROWS'(1) << row);
               e_col = row_bits(pick(s, e_ph), row);
            end
            t++;
         end
      end
      @(posedge Clock);
      #1;
      check("lin", 32'(lin), 32'(e_lin));
      check("col", 32'(col), 32'(e_col));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("phase", 32'(phase), 32'(e_ph));
      check("one_cold", 32'($countones(~lin) <= 1), 32'd1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until the model sits at the start of row r (bounded).
   task automatic run_to_row(input int r);
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (t % DIV == 0 && (t / DIV) % ROWS == r) return;
         step();
      end
      check("run_to_row_timeout", 32'd0, 32'd1);
   endtask

   task automatic set_in(input logic [5:0] v);
      {Critico, Baixo, Medio, Alto, Aspersao, Gotejamento} = v;
   endtask

   initial begin
      // 1. Reset with all inputs high, then release.
      Reset = 1'b0; Enable = 1'b1; set_in(6'b111111);
      run(3);
      Reset = 1'b1;
      step();
      check("fs_first_after_reset", 32'(frame_start), 32'd1);
      step();
      check("lin_second_after_reset", 32'(lin), 32'h7e);

      // 2. Scan timing with Baixo.
      Reset = 1'b0; run(1); Reset = 1'b1;
      set_in(6'b010000);
      run(2 * FRAME);

      // 3. Alternation Medio / Gotejamento.
      set_in(6'b001001);
      run(4 * FRAME);

      // 4. Critical override, then priority.
      set_in(6'b100110);
      run(4 * FRAME);
      set_in(6'b010100);
      run(4 * FRAME);

      // 5. No tearing: Alto -> Baixo at row 3.
      set_in(6'b000100);
      run_to_row(0);
      run_to_row(3);
      set_in(6'b010000);
      run(2 * FRAME);

      // 6. Enable pause at row 4, then reset pulse mid-frame.
      run_to_row(4);
      run(1);
      Enable = 1'b0;
      run(10);
      Enable = 1'b1;
      run(2 * FRAME);
      run_to_row(2);
      run(2);
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      run(2 * FRAME);

      // Random stimulus.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) set_in(6'($urandom));
         Enable = ($urandom_range(15) != 0);
         Reset  = ($urandom_range(299) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
